ps2_keycode_receiver: RTL and testbench

//  PS/2 keyboard front end for the snake game. Synchronises and de-glitches ps2_clk/ps2_data,

---
 rtl/ps2_keycode_receiver.sv | 121 ++++++++++++
 tb/tb_ps2_keycode_receiver.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_receiver.sv
// ps2_keycode_receiver: PS/2 keyboard deframer with glitch filter and E0/F0 prefix stripping.
// Optional frame watchdog enabled by defining PS2_TIMEOUT_EN.
module ps2_keycode_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic       extended,
   output logic       new_key_strobe,
   output logic       frame_err
);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam int FW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clk_s_q, dat_s_q;
   logic          filt_q;
   logic [FW-1:0] fcnt_q;
   state_t        state_q;
   logic [2:0]    bit_q;
   logic [7:0]    sh_q, key_q;
   logic          par_q, brk_q, ext_q, ext_out_q, stb_q, err_q;
   logic          flip, fall, dat, good, tmo;

   assign flip = (clk_s_q[1] != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
   assign fall = flip && filt_q;
   assign dat  = dat_s_q[1];
   assign good = dat && (^{sh_q, par_q});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s_q <= 2'b11;
         dat_s_q <= 2'b11;
         filt_q  <= 1'b1;
         fcnt_q  <= '0;
      end else begin
         clk_s_q <= {clk_s_q[0], ps2_clk};
         dat_s_q <= {dat_s_q[0], ps2_data};
         filt_q  <= filt_q ^ flip;
         fcnt_q  <= (clk_s_q[1] == filt_q || flip) ? '0 : fcnt_q + FW'(1);
      end
   end

`ifdef PS2_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_q;
   // Fires as the count is about to reach TIMEOUT_CYCLES-1, so frame_err lands TIMEOUT_CYCLES after the last Fall.
   assign tmo = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 2));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_q <= '0;
      else     tmo_q <= (fall || state_q == IDLE || tmo) ? '0 : tmo_q + TW'(1);
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_q     <= '0;
         sh_q      <= '0;
         par_q     <= 1'b0;
         brk_q     <= 1'b0;
         ext_q     <= 1'b0;
         key_q     <= '0;
         ext_out_q <= 1'b0;
         stb_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         stb_q <= 1'b0;
         err_q <= 1'b0;
         if (tmo) begin
            state_q <= IDLE;
            bit_q   <= '0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            err_q   <= 1'b1;
         end else if (fall) begin
            case (state_q)
               IDLE: if (!dat) begin
                  state_q <= DATA;
                  bit_q   <= '0;
               end
               DATA: begin
                  sh_q    <= {dat, sh_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  state_q <= (bit_q == 3'd7) ? PARITY : DATA;
               end
               PARITY: begin
                  par_q   <= dat;
                  state_q <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (!good) err_q <= 1'b1;
                  else if (sh_q == 8'hF0) brk_q <= 1'b1;
                  else if (sh_q == 8'hE0) ext_q <= 1'b1;
                  else if (brk_q) begin
                     brk_q <= 1'b0;
                     ext_q <= 1'b0;
                  end else begin
                     key_q     <= sh_q;
                     ext_out_q <= ext_q;
                     ext_q     <= 1'b0;
                     stb_q     <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign keycode        = key_q;
   assign extended       = ext_out_q;
   assign new_key_strobe = stb_q;
   assign frame_err      = err_q;
endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// tb_ps2_keycode_receiver: directed PS/2 frames with hand-computed keycodes, strobes and errors.
module tb_ps2_keycode_receiver;
   localparam int FL  = 8;
   localparam int TMO = 500;

   logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [7:0] keycode;
   logic       extended, new_key_strobe, frame_err;

   int n_chk = 0, n_err = 0;
   int cyc = 0, stb_cnt = 0, err_cnt = 0, stb_cyc = 0, err_cyc = 0, fall_cyc = 0;
   int s0, e0;
   logic overlap = 1'b0;

   ps2_keycode_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keycode(keycode), .extended(extended),
      .new_key_strobe(new_key_strobe), .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (new_key_strobe) begin stb_cnt <= stb_cnt + 1; stb_cyc <= cyc; end
      if (frame_err) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
      if (new_key_strobe && frame_err) overlap <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Data changes mid-high; each bit is 40 clk cycles, all edges driven 1 ns after a posedge.
   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         #100 ps2_clk = 1'b0;
         fall_cyc = cyc;
         #200 ps2_clk = 1'b1;
         #100;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      send_bits({stop, ~^b ^ bad_par, b, 1'b0}, 11);
      #200;
   endtask

   task automatic snap;
      s0 = stb_cnt;
      e0 = err_cnt;
   endtask

   initial begin
      @(posedge clk);
      #1;
      check("rst_key", keycode, 8'h00);
      check("rst_ext", extended, 1'b0);
      check("rst_stb", new_key_strobe, 1'b0);
      check("rst_err", frame_err, 1'b0);
      #100 rst = 1'b0;
      #200;

      snap();
      send_frame(8'h1B, 1'b0, 1'b1);
      check("t1_stb_cnt", stb_cnt - s0, 1);
      check("t1_key", keycode, 8'h1B);
      check("t1_ext", extended, 1'b0);
      check("t1_latency", stb_cyc - fall_cyc, FL + 2);
      check("t1_err_cnt", err_cnt - e0, 0);

      snap();
      send_frame(8'hE0, 1'b0, 1'b1);
      check("t2_e0_no_stb", stb_cnt - s0, 0);
      send_frame(8'h75, 1'b0, 1'b1);
      check("t2_stb_cnt", stb_cnt - s0, 1);
      check("t2_key", keycode, 8'h75);
      check("t2_ext", extended, 1'b1);

      snap();
      send_frame(8'h4D, 1'b0, 1'b1);
      check("t3_make_cnt", stb_cnt - s0, 1);
      check("t3_make_key", keycode, 8'h4D);
      check("t3_make_ext", extended, 1'b0);
      snap();
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h4D, 1'b0, 1'b1);
      check("t3_brk_no_stb", stb_cnt - s0, 0);
      check("t3_brk_key", keycode, 8'h4D);

      snap();
      send_frame(8'h4D, 1'b1, 1'b1);
      check("t4_par_err", err_cnt - e0, 1);
      check("t4_par_no_stb", stb_cnt - s0, 0);
      check("t4_par_key", keycode, 8'h4D);
      snap();
      send_frame(8'h29, 1'b0, 1'b0);
      check("t4_stop_err", err_cnt - e0, 1);
      check("t4_stop_no_stb", stb_cnt - s0, 0);
      snap();
      ps2_clk = 1'b0;
      #30 ps2_clk = 1'b1;
      #300;
      check("t4_glitch_stb", stb_cnt - s0, 0);
      check("t4_glitch_err", err_cnt - e0, 0);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("t4_after_glitch_cnt", stb_cnt - s0, 1);
      check("t4_after_glitch_key", keycode, 8'h1C);

      send_bits({1'b1, ~^8'h76, 8'h76, 1'b0}, 5);
      rst = 1'b1;
      #50;
      check("t5_rst_key", keycode, 8'h00);
      check("t5_rst_ext", extended, 1'b0);
      check("t5_rst_stb", new_key_strobe, 1'b0);
      check("t5_rst_err", frame_err, 1'b0);
      #100 rst = 1'b0;
      #200;
      snap();
      send_frame(8'h2D, 1'b0, 1'b1);
      check("t5_stb_cnt", stb_cnt - s0, 1);
      check("t5_key", keycode, 8'h2D);
      check("t5_err_cnt", err_cnt - e0, 0);

`ifdef PS2_TIMEOUT_EN
      snap();
      send_bits({1'b1, ~^8'h55, 8'h55, 1'b0}, 6);
      for (int i = 0; i < 3 * TMO && err_cnt == e0; i++) @(posedge clk);
      #1;
      check("t6_tmo_seen", err_cnt - e0, 1);
      check("t6_tmo_delay", err_cyc - fall_cyc, TMO + FL + 1);
      snap();
      send_frame(8'h76, 1'b0, 1'b1);
      check("t6_stb_cnt", stb_cnt - s0, 1);
      check("t6_key", keycode, 8'h76);
`endif

      check("no_overlap", overlap, 1'b0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
